// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Pure declarations; no logic and no latency.
// No handshake; consumed by hazard_ctrl, mdu_timer and the hazard interface.
package hazard_pkg;

  // Register-number width of the integer register file
  localparam int REG_W          = 5;
  // Default multiply/divide occupancy in cycles (legal 1..255)
  localparam int MDU_CYCLES_DEF = 32;
  // Width of the multicycle occupancy down-counter
  localparam int CNT_W          = 8;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline status inputs and per-stage control outputs of the hazard controller.
// Wires only; no latency.
// No backpressure of its own; the enables it carries are the pipeline's backpressure.
interface hazard_ctrl_if;
  import hazard_pkg::*;

  // Status from the pipeline
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] ex_rd;
  logic             ex_memread;
  logic             ex_branch;
  logic             ex_zero;
  logic             ex_mdu_start;
  logic             mem_stall;

  // Control back to the pipeline
  logic             pc_wen;
  logic             ifid_wen;
  logic             idex_wen;
  logic             exmem_wen;
  logic             memwb_wen;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             mdu_busy;
  logic [15:0]      stall_count;

  // Pipeline side: reports status, obeys enables/flushes
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_memread,
           ex_branch, ex_zero, ex_mdu_start, mem_stall,
    input  pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
           ifid_flush, idex_flush, exmem_flush, mdu_busy, stall_count
  );

  // Controller side: observes status, drives enables/flushes
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_memread,
           ex_branch, ex_zero, ex_mdu_start, mem_stall,
    output pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
           ifid_flush, idex_flush, exmem_flush, mdu_busy, stall_count
  );

endinterface

// File: rtl/hazard_ctrl_mdu_timer.sv
// Tracks multicycle multiply/divide occupancy: RUN/MDU_WAIT state plus down-counter.
// State visible the cycle after a start is accepted; counter loads MDU_CYCLES-1.
// i_hold freezes state and counter entirely (memory stall).
module mdu_timer
  import hazard_pkg::*;
#(
  parameter int MDU_CYCLES = MDU_CYCLES_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_hold,
  input  logic             i_start,
  output hz_state_t        o_state,
  output logic [CNT_W-1:0] o_cnt
);

  hz_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  hz_state_t        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // State and counter registers; reset aborts any wait in progress
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: load on start in RUN, count down while waiting, leave at zero
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!i_hold) begin
      case (r_state)
        ST_RUN: begin
          if (i_start) begin
            w_state_nxt = ST_MDU_WAIT;
            w_cnt_nxt   = CNT_W'(MDU_CYCLES - 1);
          end
        end
        ST_MDU_WAIT: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_state = r_state;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, taken branch, multicycle MDU and memory stalls.
// Enables/flushes are combinational from registered state and current inputs (zero latency).
// mem_stall freezes every pipeline register and the MDU timer; nothing is flushed.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_CYCLES = MDU_CYCLES_DEF
) (
  input  logic          clock,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  hz_state_t        w_state;
  logic [CNT_W-1:0] w_cnt;
  logic             w_mdu_stall;
  logic             w_mdu_held;
  logic             w_branch_taken;
  logic             w_load_use;
  logic             w_rs_hit;
  logic             w_rt_hit;

  logic             w_pc_wen;
  logic             w_ifid_wen;
  logic             w_idex_wen;
  logic             w_exmem_wen;
  logic             w_memwb_wen;
  logic             w_ifid_flush;
  logic             w_idex_flush;
  logic             w_exmem_flush;
  logic             w_mdu_busy;

  logic [15:0]      r_stall_count;

  mdu_timer #(
    .MDU_CYCLES (MDU_CYCLES)
  ) u_mdu_timer (
    .clock   (clock),
    .reset   (reset),
    .i_hold  (hz.mem_stall),
    .i_start (hz.ex_mdu_start),
    .o_state (w_state),
    .o_cnt   (w_cnt)
  );

  // Stall sources; a start outside RUN is ignored because the release cycle follows RUN rules
  assign w_mdu_held     = (w_state == ST_MDU_WAIT) && (w_cnt != '0);
  assign w_mdu_stall    = ((w_state == ST_RUN) && hz.ex_mdu_start) || w_mdu_held;
  assign w_branch_taken = hz.ex_branch && hz.ex_zero;
  assign w_rs_hit       = hz.id_use_rs && (hz.id_rs == hz.ex_rd);
  assign w_rt_hit       = hz.id_use_rt && (hz.id_rt == hz.ex_rd);
  assign w_load_use     = hz.ex_memread && (hz.ex_rd != '0) && (w_rs_hit || w_rt_hit);

  // Output decode in priority order: reset, memory stall, MDU, taken branch, load-use
  always_comb begin
    w_pc_wen      = 1'b1;
    w_ifid_wen    = 1'b1;
    w_idex_wen    = 1'b1;
    w_exmem_wen   = 1'b1;
    w_memwb_wen   = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_mdu_busy    = 1'b0;
    if (reset) begin
      w_pc_wen      = 1'b0;
      w_ifid_wen    = 1'b0;
      w_idex_wen    = 1'b0;
      w_exmem_wen   = 1'b0;
      w_memwb_wen   = 1'b0;
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
    end else if (hz.mem_stall) begin
      w_pc_wen      = 1'b0;
      w_ifid_wen    = 1'b0;
      w_idex_wen    = 1'b0;
      w_exmem_wen   = 1'b0;
      w_memwb_wen   = 1'b0;
      w_mdu_busy    = w_mdu_held;
    end else if (w_mdu_stall) begin
      // Hold front end, bubble into EX/MEM, let older instructions drain
      w_pc_wen      = 1'b0;
      w_ifid_wen    = 1'b0;
      w_idex_wen    = 1'b0;
      w_exmem_flush = 1'b1;
      w_mdu_busy    = 1'b1;
    end else if (w_branch_taken) begin
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
    end else if (w_load_use) begin
      w_pc_wen      = 1'b0;
      w_ifid_wen    = 1'b0;
      w_idex_flush  = 1'b1;
    end
  end

  // Saturating count of cycles in which the PC did not advance
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (!w_pc_wen && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign hz.pc_wen      = w_pc_wen;
  assign hz.ifid_wen    = w_ifid_wen;
  assign hz.idex_wen    = w_idex_wen;
  assign hz.exmem_wen   = w_exmem_wen;
  assign hz.memwb_wen   = w_memwb_wen;
  assign hz.ifid_flush  = w_ifid_flush;
  assign hz.idex_flush  = w_idex_flush;
  assign hz.exmem_flush = w_exmem_flush;
  assign hz.mdu_busy    = w_mdu_busy;
  assign hz.stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with MDU_CYCLES=4.
// Inputs change 1 time unit after posedge; outputs are checked before the next edge.
// Expected values are hand-computed constants.
module tb_hazard_ctrl;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .MDU_CYCLES (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Control vector: {pc,ifid,idex,exmem,memwb wen, ifid,idex,exmem flush, mdu_busy}
  logic [8:0] w_ctl;
  assign w_ctl = {hz.pc_wen, hz.ifid_wen, hz.idex_wen, hz.exmem_wen, hz.memwb_wen,
                  hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.mdu_busy};

  localparam logic [8:0] V_DEF  = 9'b11111_000_0;
  localparam logic [8:0] V_RST  = 9'b00000_111_0;
  localparam logic [8:0] V_LU   = 9'b00111_010_0;
  localparam logic [8:0] V_BR   = 9'b11111_110_0;
  localparam logic [8:0] V_MDU  = 9'b00011_001_1;
  localparam logic [8:0] V_MSW  = 9'b00000_000_1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    hz.id_rs        = '0;
    hz.id_rt        = '0;
    hz.id_use_rs    = 1'b0;
    hz.id_use_rt    = 1'b0;
    hz.ex_rd        = '0;
    hz.ex_memread   = 1'b0;
    hz.ex_branch    = 1'b0;
    hz.ex_zero      = 1'b0;
    hz.ex_mdu_start = 1'b0;
    hz.mem_stall    = 1'b0;
  endtask

  task automatic set_load_use_rs(input logic [4:0] rd);
    hz.ex_memread = 1'b1;
    hz.ex_rd      = rd;
    hz.id_rs      = rd;
    hz.id_use_rs  = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    idle_inputs();
    tick();
    tick();
    #1;
    check_eq("reset_ctl", 32'(w_ctl), 32'(V_RST));
    check_eq("reset_cnt", 32'(hz.stall_count), 32'd0);

    // Idle defaults
    reset = 1'b0;
    #1;
    check_eq("idle_ctl", 32'(w_ctl), 32'(V_DEF));
    tick();
    check_eq("idle_cnt", 32'(hz.stall_count), 32'd0);

    // Load-use on rs
    set_load_use_rs(5'd8);
    #1;
    check_eq("lu_rs_ctl", 32'(w_ctl), 32'(V_LU));
    tick();
    idle_inputs();
    #1;
    check_eq("lu_after_ctl", 32'(w_ctl), 32'(V_DEF));
    check_eq("lu_rs_cnt", 32'(hz.stall_count), 32'd1);

    // Load to r0 never stalls
    set_load_use_rs(5'd0);
    #1;
    check_eq("lu_r0_ctl", 32'(w_ctl), 32'(V_DEF));
    tick();
    check_eq("lu_r0_cnt", 32'(hz.stall_count), 32'd1);

    // Load-use on rt; then same match but rt not used
    idle_inputs();
    hz.ex_memread = 1'b1;
    hz.ex_rd      = 5'd5;
    hz.id_rt      = 5'd5;
    hz.id_use_rt  = 1'b1;
    #1;
    check_eq("lu_rt_ctl", 32'(w_ctl), 32'(V_LU));
    tick();
    hz.id_use_rt = 1'b0;
    #1;
    check_eq("lu_rt_unused_ctl", 32'(w_ctl), 32'(V_DEF));
    tick();
    check_eq("lu_rt_cnt", 32'(hz.stall_count), 32'd2);

    // Branch taken beats load-use
    idle_inputs();
    set_load_use_rs(5'd8);
    hz.ex_branch = 1'b1;
    hz.ex_zero   = 1'b1;
    #1;
    check_eq("br_lu_ctl", 32'(w_ctl), 32'(V_BR));
    tick();
    check_eq("br_cnt", 32'(hz.stall_count), 32'd2);

    // Branch not taken: falls through to load-use
    hz.ex_zero = 1'b0;
    #1;
    check_eq("br_nt_lu_ctl", 32'(w_ctl), 32'(V_LU));
    tick();
    check_eq("br_nt_cnt", 32'(hz.stall_count), 32'd3);

    // MDU start with taken branch: MDU wins; 4 stalled cycles then release
    idle_inputs();
    hz.ex_mdu_start = 1'b1;
    hz.ex_branch    = 1'b1;
    hz.ex_zero      = 1'b1;
    #1;
    check_eq("mdu_start_ctl", 32'(w_ctl), 32'(V_MDU));
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("mdu_wait%0d_ctl", i), 32'(w_ctl), 32'(V_MDU));
      tick();
    end
    // Release cycle: a new start here is ignored
    hz.ex_mdu_start = 1'b1;
    #1;
    check_eq("mdu_release_ctl", 32'(w_ctl), 32'(V_DEF));
    check_eq("mdu_cnt", 32'(hz.stall_count), 32'd7);
    tick();
    hz.ex_mdu_start = 1'b0;
    #1;
    check_eq("mdu_after_ctl", 32'(w_ctl), 32'(V_DEF));
    tick();
    check_eq("mdu_after_cnt", 32'(hz.stall_count), 32'd7);

    // mem_stall for 3 cycles while waiting with cnt=2
    hz.ex_mdu_start = 1'b1;
    tick();
    hz.ex_mdu_start = 1'b0;
    tick();
    hz.mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("msw%0d_ctl", i), 32'(w_ctl), 32'(V_MSW));
      tick();
    end
    hz.mem_stall = 1'b0;
    #1;
    check_eq("msw_resume2_ctl", 32'(w_ctl), 32'(V_MDU));
    tick();
    #1;
    check_eq("msw_resume1_ctl", 32'(w_ctl), 32'(V_MDU));
    tick();
    #1;
    check_eq("msw_release_ctl", 32'(w_ctl), 32'(V_DEF));
    check_eq("msw_cnt", 32'(hz.stall_count), 32'd14);

    // Reset in the middle of a wait
    tick();
    hz.ex_mdu_start = 1'b1;
    tick();
    hz.ex_mdu_start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check_eq("rst_wait_ctl", 32'(w_ctl), 32'(V_RST));
    tick();
    reset = 1'b0;
    #1;
    check_eq("rst_after_ctl", 32'(w_ctl), 32'(V_DEF));
    check_eq("rst_after_cnt", 32'(hz.stall_count), 32'd0);
    tick();
    #1;
    check_eq("rst_after2_ctl", 32'(w_ctl), 32'(V_DEF));

    // Saturation of the stall counter
    set_load_use_rs(5'd8);
    for (int i = 0; i < 65534; i++) tick();
    check_eq("sat_pre_cnt", 32'(hz.stall_count), 32'h0000FFFE);
    for (int i = 0; i < 6; i++) tick();
    check_eq("sat_cnt", 32'(hz.stall_count), 32'h0000FFFF);
    idle_inputs();
    tick();
    check_eq("sat_hold_cnt", 32'(hz.stall_count), 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
